// File: rtl/rgb_to_yuv_pkg.sv
// rgb_to_yuv_pkg: shared states, base addresses and BT.601 fixed-point constants for the RGB-to-YUV encoder.
package rgb_to_yuv_pkg;
  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RD4, RD5, WAIT1, WAIT2, CALC, WR_Y0, WR_Y1, WR_U, WR_V, DONE
  } state_t;
  localparam logic [17:0] DEFAULT_Y_BASE = 18'd0;
  localparam logic [17:0] DEFAULT_U_BASE = 18'd38400;
  localparam logic [17:0] DEFAULT_V_BASE = 18'd57600;
  localparam logic [17:0] DEFAULT_RGB_BASE = 18'd146944;
  localparam logic signed [17:0] C_YR = 18'sd66;
  localparam logic signed [17:0] C_YG = 18'sd129;
  localparam logic signed [17:0] C_YB = 18'sd25;
  localparam logic signed [17:0] C_UR = -18'sd38;
  localparam logic signed [17:0] C_UG = -18'sd74;
  localparam logic signed [17:0] C_UB = 18'sd112;
  localparam logic signed [17:0] C_VR = 18'sd112;
  localparam logic signed [17:0] C_VG = -18'sd94;
  localparam logic signed [17:0] C_VB = -18'sd18;
  localparam logic signed [17:0] OFS_Y = 18'sd16;
  localparam logic signed [17:0] OFS_C = 18'sd128;
  localparam logic signed [17:0] RND = 18'sd128;
  function automatic logic [7:0] clip8(input logic signed [17:0] x);
    return x < 0 ? 8'd0 : x > 18'sd255 ? 8'd255 : x[7:0];
  endfunction
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
  endfunction
endpackage

// File: rtl/rgb_to_yuv_encoder_pixel.sv
// rgb2yuv_pixel: combinational BT.601 converter, 8-bit RGB in, clipped 8-bit YUV out.
module rgb2yuv_pixel
  import rgb_to_yuv_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);
  logic signed [17:0] rs, gs, bs;
  assign rs = $signed({10'd0, r});
  assign gs = $signed({10'd0, g});
  assign bs = $signed({10'd0, b});
  assign y = clip8(((C_YR * rs + C_YG * gs + C_YB * bs + RND) >>> 8) + OFS_Y);
  assign u = clip8(((C_UR * rs + C_UG * gs + C_UB * bs + RND) >>> 8) + OFS_C);
  assign v = clip8(((C_VR * rs + C_VG * gs + C_VB * bs + RND) >>> 8) + OFS_C);
endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: SRAM frame RGB-to-YUV converter with 2:1 chroma downsampling; UV_AVG_FILTER_EN averages chroma pairs.
module rgb_to_yuv_encoder
  import rgb_to_yuv_pkg::*;
#(
  parameter int IMG_PIXELS = 76800,
  parameter logic [17:0] Y_BASE = DEFAULT_Y_BASE,
  parameter logic [17:0] U_BASE = DEFAULT_U_BASE,
  parameter logic [17:0] V_BASE = DEFAULT_V_BASE,
  parameter logic [17:0] RGB_BASE = DEFAULT_RGB_BASE
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic        Done,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);
  localparam int GROUPS = IMG_PIXELS / 4;
  localparam int GW = $clog2(GROUPS + 1);
  state_t st, nxt;
  logic [GW-1:0] g, gn;
  logic last;
  logic [95:0] pix;
  logic [7:0] yc[4], uc[4], vc[4];
  logic [63:0] res;
  logic [47:0] res_q;
  logic [17:0] addr_n;
  logic [15:0] wd_n;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_px
    rgb2yuv_pixel u_px (
      .r(pix[95-24*i -: 8]), .g(pix[87-24*i -: 8]), .b(pix[79-24*i -: 8]),
      .y(yc[i]), .u(uc[i]), .v(vc[i])
    );
  end
`ifdef UV_AVG_FILTER_EN
  assign res = {yc[0], yc[1], yc[2], yc[3], avg8(uc[0], uc[1]), avg8(uc[2], uc[3]),
                avg8(vc[0], vc[1]), avg8(vc[2], vc[3])};
`else
  assign res = {yc[0], yc[1], yc[2], yc[3], uc[0], uc[2], vc[0], vc[2]};
`endif
  assign last = g == GW'(GROUPS - 1);
  // Outputs are registered from the next state so each is valid during its own state.
  always_comb begin
    nxt = st == IDLE ? (Enable ? RD0 : IDLE) : st == WR_V ? (last ? DONE : RD0) :
          st == DONE ? IDLE : state_t'(st + 4'd1);
    gn = st == IDLE ? '0 : (st == WR_V && !last) ? g + 1'b1 : g;
    addr_n = nxt inside {[RD0:RD5]} ? RGB_BASE + 18'(gn) * 18'd6 + 18'(nxt - RD0) :
             nxt == WR_Y0 ? Y_BASE + (18'(gn) << 1) :
             nxt == WR_Y1 ? Y_BASE + (18'(gn) << 1) + 18'd1 :
             nxt == WR_U ? U_BASE + 18'(gn) :
             nxt == WR_V ? V_BASE + 18'(gn) : SRAM_address;
    wd_n = nxt == WR_Y0 ? res[63:48] : nxt == WR_Y1 ? res_q[47:32] :
           nxt == WR_U ? res_q[31:16] : nxt == WR_V ? res_q[15:0] : SRAM_write_data;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st <= IDLE;
      g <= '0;
      Done <= 1'b0;
      SRAM_we_n <= 1'b1;
      SRAM_address <= '0;
      SRAM_write_data <= '0;
    end else begin
      st <= nxt;
      g <= gn;
      Done <= nxt == DONE;
      SRAM_we_n <= !(nxt inside {[WR_Y0:WR_V]});
      SRAM_address <= addr_n;
      SRAM_write_data <= wd_n;
    end
  end
  // Word k of a group arrives two cycles after its read, i.e. during RD2..WAIT2.
  always_ff @(posedge Clock) begin
    if (st inside {[RD2:WAIT2]}) pix <= {pix[79:0], SRAM_read_data};
    if (st == CALC) res_q <= res[47:0];
  end
endmodule
